// File: rtl/carry_chain_pkg.sv
// Shared definitions for the carry-chain accumulator slice.
//   SAT_WRAP / SAT_CLAMP : values for the accumulator SAT parameter.
//   op_e                 : decoded per-cycle operation of the accumulator.
//   carry_ovf()          : unsigned overflow/underflow event from the
//                          operation direction and the chain carry-out.
package carry_chain_pkg;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_ADD  = 2'd2,
    OP_SUB  = 2'd3
  } op_e;

  // Add overflows when the carry leaves the top bit; subtract underflows
  // when it does not (carry-out of a subtract means "no borrow").
  function automatic logic carry_ovf(input logic sub, input logic co);
    return sub ? ~co : co;
  endfunction

endpackage

// File: rtl/carry_chain_n.sv
// Combinational WIDTH-bit carry mux chain, one mux plus XOR per bit.
// Ports:
//   A   : first operand; also the generate input of each carry mux
//   B   : second operand (already inverted by the caller for subtract)
//   CI  : chain carry-in
//   SUM : A + B + CI, low WIDTH bits
//   CO  : carry out of the most significant bit
module carry_chain_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic [WIDTH-1:0] SUM,
  output logic             CO
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] prop;

  assign carry[0] = CI;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Propagate selects the incoming carry; otherwise A[i] (== B[i])
    // is both bits' value and therefore the generated carry.
    assign prop[i]    = A[i] ^ B[i];
    assign carry[i+1] = prop[i] ? carry[i] : A[i];
    assign SUM[i]     = prop[i] ^ carry[i];
  end

  assign CO = carry[WIDTH];

endmodule

// File: rtl/carry_chain_accumulator.sv
// Registered accumulator stage behind a carry mux chain.
// Ports:
//   C     : clock, rising edge
//   RST_N : asynchronous active-low reset
//   CE    : clock enable; stage acts only when high
//   LD    : load D into Q (wins over arithmetic)
//   SUB   : 0 = Q + D, 1 = Q - D
//   D     : operand / load value
//   Q     : accumulator value
//   CO    : registered chain carry-out (subtract: 1 = no borrow)
//   OVF   : sticky unsigned overflow/underflow, cleared by reset or load
//   VALID : high for the cycle after each enabled edge
// Parameters:
//   WIDTH : data width (>= 2)
//   SAT   : SAT_WRAP wraps on overflow, SAT_CLAMP clamps unsigned
module carry_chain_accumulator
  import carry_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SAT   = SAT_WRAP
) (
  input  logic             C,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             LD,
  input  logic             SUB,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF,
  output logic             VALID
);

  op_e              op;
  logic [WIDTH-1:0] chain_b;
  logic [WIDTH-1:0] chain_sum;
  logic             chain_co;
  logic             ovf_event;

  logic [WIDTH-1:0] q_next;
  logic             co_next;
  logic             ovf_next;

  // Subtract is Q + ~D + 1: invert the operand and feed SUB as carry-in.
  assign chain_b = SUB ? ~D : D;

  carry_chain_n #(
    .WIDTH (WIDTH)
  ) u_chain (
    .A   (Q),
    .B   (chain_b),
    .CI  (SUB),
    .SUM (chain_sum),
    .CO  (chain_co)
  );

  assign ovf_event = carry_ovf(SUB, chain_co);

  always_comb begin
    op = OP_HOLD;
    if (CE) begin
      if (LD)       op = OP_LOAD;
      else if (SUB) op = OP_SUB;
      else          op = OP_ADD;
    end
  end

  always_comb begin
    q_next   = Q;
    co_next  = CO;
    ovf_next = OVF;
    unique case (op)
      OP_HOLD: ;
      OP_LOAD: begin
        q_next   = D;
        co_next  = 1'b0;
        ovf_next = 1'b0;
      end
      OP_ADD, OP_SUB: begin
        q_next   = chain_sum;
        co_next  = chain_co;
        ovf_next = OVF | ovf_event;
        if (SAT == SAT_CLAMP && ovf_event) begin
          q_next = (op == OP_ADD) ? '1 : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      Q     <= '0;
      CO    <= 1'b0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
    end else begin
      Q     <= q_next;
      CO    <= co_next;
      OVF   <= ovf_next;
      VALID <= CE;
    end
  end

endmodule

// File: doc/carry_chain_accumulator.md
Name: carry_chain_accumulator

Overview:
- Registered accumulator stage that consumes the per-bit carry mux chain (O = S ? CI : DI).
- Per bit, S = Q[i] ^ B[i] (propagate) and DI = Q[i] (generate); the chain's sum and final carry are registered each enabled cycle.
- Sits directly downstream of the carry mux chain, in the same slot as a CARRY4 → flip-flop pair.
- Provides load, add/subtract, sticky unsigned overflow, optional saturation, and a one-cycle result-valid strobe.

Parameters:
- WIDTH, 8: accumulator and operand width in bits (>= 2).
- SAT, 0: 0 = wrap on overflow; 1 = clamp unsigned (all-ones on add overflow, zero on subtract underflow).

Ports:
- C  input  1  clock; all state changes on its rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- CE  input  1  clock enable; the stage acts only when high.
- LD  input  1  load D into Q (takes priority over arithmetic).
- SUB  input  1  0 = Q + D, 1 = Q - D.
- D  input  WIDTH  operand or load value.
- Q  output  WIDTH  accumulator value.
- CO  output  1  registered chain carry-out of the last operation (subtract: 1 = no borrow).
- OVF  output  1  sticky unsigned overflow/underflow flag.
- VALID  output  1  high for the one cycle after each enabled (CE=1) edge.

Behaviour:
- Reset: RST_N low forces Q=0, CO=0, OVF=0, VALID=0 immediately, independent of C. The assertion may land mid-operation; the first edge after RST_N rises is processed normally.
- CE=0: Q, CO and OVF hold; VALID <= 0.
- CE=1, LD=1:
  - Q <= D, CO <= 0, OVF <= 0, VALID <= 1.
  - SUB is ignored.
- CE=1, LD=0, arithmetic:
  - B = SUB ? ~D : D; chain carry-in CI0 = SUB.
  - Per bit i: S_i = Q[i]^B[i], DI_i = Q[i], C_{i+1} = S_i ? C_i : DI_i, sum_i = S_i ^ C_i.
  - Carry-out = C_WIDTH.
  - Overflow event: (SUB=0 and C_WIDTH=1) or (SUB=1 and C_WIDTH=0).
- Register update on arithmetic:
  - Q <= sum, unless SAT=1 and an overflow event occurs: then Q <= all-ones (add) or 0 (subtract).
  - CO <= C_WIDTH.
  - OVF <= OVF | event.
  - VALID <= 1.
- Latency: one cycle from the enabled edge to Q/CO/OVF. VALID marks that update.
- Full-chain propagation: a carry must ripple across all WIDTH bits within one cycle. No pipelining inside the chain.
- Subtract of an equal value (Q == D): Q <= 0, CO <= 1, no overflow.
- Back-to-back enabled cycles are allowed every cycle; each uses the Q registered by the previous edge.
- OVF clears only on reset or on LD.

Decomposition:
- Shared package carry_chain_pkg:
  - localparam constants SAT_WRAP=0 and SAT_CLAMP=1.
  - Function carry_ovf(sub, co) returning the overflow event.
- Sub-module carry_chain_n (combinational, parameter WIDTH):
  - Inputs A, B, CI; outputs SUM and CO.
  - Built as WIDTH instances of the per-bit carry mux plus XOR.
  - The accumulator wraps it with registers and control.

Test Plan (WIDTH=8):
1. RST_N pulled low between edges while Q=0x5A, OVF=1 → Q=0x00, CO=0, OVF=0, VALID=0 without waiting for an edge.
2. LD D=0xF0, then add D=0x20 → Q=0x10, CO=1, OVF=1 (SAT=0). Same sequence with SAT=1 → Q=0xFF, CO=1, OVF=1.
3. LD 0x05; SUB D=0x03 → Q=0x02, CO=1, OVF=0. SUB D=0x03 again → Q=0xFF, CO=0, OVF=1. With SAT=1 the second step → Q=0x00.
4. Q=0xFF, add D=0x01 (full ripple) → Q=0x00, CO=1; VALID high exactly one cycle after the edge.
5. CE=0 for 3 cycles with D=0x7F, SUB toggling → Q, CO, OVF unchanged; VALID=0 throughout.
6. With OVF=1, drive CE=1, LD=1, SUB=1, D=0x33 → Q=0x33, CO=0, OVF=0 (load wins).
